pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit; successor to the plain pc register. Holds the fetch PC and
//  selects the next PC by priority: trap, redirect (branch/jump), return-address stack (RAS)
//  pop, stall, sequential. Adds a halt state, a misaligned-target fault and a circular RAS.
//  Sits between the branch/trap logic and the instruction-memory address port.
// PARAMETERS
//  XLEN          32  address width in bits
//  RESET_VECTOR  0   PC value loaded on reset (XLEN bits)
//  IALIGN        4   instruction alignment in bytes (2 or 4); also the sequential increment
//  RAS_DEPTH     4   return-address stack entries (power of two, >=2)
// PORTS
//  clk              in   1     clock, all state changes on rising edge
//  reset            in   1     synchronous, active-low reset
//  stall            in   1     hold PC this cycle
//  halt_req         in   1     enter HALTED at the next boundary
//  resume           in   1     leave HALTED
//  redirect_valid   in   1     branch/jump taken
//  redirect_target  in   XLEN  branch/jump target; also ret fallback when RAS is empty
//  call_valid       in   1     current redirect is a call: push pc_out+IALIGN
//  ret_valid        in   1     return: next PC = RAS top (pop)
//  trap_valid       in   1     exception/interrupt entry
//  trap_vector      in   XLEN  trap handler address (mtvec)
//  pc_out           out  XLEN  current fetch PC
//  pc_next_seq      out  XLEN  pc_out + IALIGN (combinational, wraps mod 2^XLEN)
//  pc_valid         out  1     pc_out is a legal fetch address this cycle
//  fault            out  1     misaligned target captured; held until trap_valid
//  fault_addr       out  XLEN  offending target
//  ras_empty        out  1     RAS count == 0
//  ras_full         out  1     RAS count == RAS_DEPTH
// BEHAVIOUR
//  Reset (reset==0 at edge): pc_out=RESET_VECTOR, state=BOOT, pc_valid=0, fault=0,
//   fault_addr=0, RAS count=0, RAS pointer=0. Reset mid-operation discards everything.
//  FSM: BOOT -> RUN after exactly one cycle (pc_out stays RESET_VECTOR, pc_valid=1 in RUN).
//   RUN -> HALTED on halt_req (PC holds, pc_valid=0); HALTED -> RUN on resume, PC unchanged.
//   RUN -> FAULT when the selected target has target % IALIGN != 0: pc_out NOT updated,
//   fault=1, fault_addr=target, pc_valid=0. FAULT -> RUN only on trap_valid.
//  Next-PC priority in RUN: trap_valid > redirect_valid > ret_valid > stall > pc+IALIGN.
//   trap_valid overrides stall, halt and FAULT; trap_vector is alignment-checked like all targets.
//   halt_req with a redirect/trap the same cycle: the redirect/trap loads first, halt next cycle.
//   stall never blocks trap or redirect; it blocks sequential advance and ret.
//  Latency: any load visible on pc_out one cycle after the input is sampled; no bypass.
//  Arithmetic: unsigned, mod 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0 with no flag.
//  RAS: circular buffer, ptr indexes next free slot.
//   call (with redirect_valid): write pc_out+IALIGN at ptr, ptr++, count=min(count+1,DEPTH);
//   when full the oldest entry is overwritten silently.
//   ret: target=entry[ptr-1], ptr--, count--; if empty, target=redirect_target, no pop.
//   call and ret together: top entry replaced in place (count unchanged), target=redirect_target.
//   call_valid without redirect_valid is ignored. RAS not updated on trap, fault or when halted.
// STRUCTURE
//  pc_pkg: typedef enum {BOOT,RUN,HALTED,FAULT} pc_state_t; XLEN-sized addr_t;
//   localparam IALIGN mask helpers.
//  Sub-module pc_ras (RAS storage, ptr/count, push/pop/replace); the FSM and next-PC mux stay in pc_unit.
// TESTING
//  1 reset low 2 cycles, release -> BOOT 1 cycle, pc_out=0, pc_valid=0; then 4, 8, 0xC each cycle.
//  2 stall=1 at pc 0x8 for 3 cycles -> pc holds 0x8; redirect 0x40 during stall -> pc=0x40 next.
//  3 redirect_target=0x42 (IALIGN=4) -> fault=1, fault_addr=0x42, pc holds;
//    trap_vector=0x100 -> pc=0x100, fault=0.
//  4 calls at 0x10,0x20,0x30,0x40,0x50 (DEPTH=4) -> ras_full; 4 rets -> 0x54,0x44,0x34,0x24;
//    5th ret -> redirect_target used, ras_empty=1.
//  5 halt_req at pc 0x20 -> pc_valid=0, pc holds 0x20 for 5 cycles; resume -> 0x24 next.
//  6 pc=0xFFFF_FFFC sequential -> 0x0; reset low mid-FAULT -> pc=RESET_VECTOR, fault=0, RAS empty.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
// Holds the FSM state encoding and the alignment check used on every loaded target.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED,
        FAULT
    } pc_state_t;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [XLEN_DEFAULT-1:0] addr_t;

    // Only the low bits matter for IALIGN of 2 or 4, so a cast to addr_t is lossless here.
    function automatic logic misaligned(input addr_t addr, input int ialign);
        return (addr & addr_t'(ialign - 1)) != '0;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: ptr names the next free slot, count saturates at DEPTH.
// When full, a push silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top_addr,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign top_addr = mem[ptr - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (replace) begin
            if (empty) begin
                ptr   <= ptr + PTR_W'(1);
                count <= CNT_W'(1);
            end
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Replace on an empty stack degenerates to a plain push.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (replace && !empty)    mem[ptr - PTR_W'(1)] <= push_addr;
            else if (push || replace) mem[ptr] <= push_addr;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC register, BOOT/RUN/HALTED/FAULT control and next-PC priority mux
// (trap > redirect > halt > ret > stall > sequential), with a circular return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call_valid,
    input  logic            ret_valid,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr,
    output logic            ras_empty,
    output logic            ras_full
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            halt_pend_q, halt_pend_d;

    logic            load;
    logic [XLEN-1:0] target;
    logic            want_push, want_pop, want_replace;
    logic            ras_push, ras_pop, ras_replace;
    logic [XLEN-1:0] ras_top;

    assign pc_out      = pc_q;
    assign pc_next_seq = pc_q + XLEN'(IALIGN);
    assign pc_valid    = (state_q == RUN);
    assign fault       = (state_q == FAULT);
    assign fault_addr  = fault_addr_q;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_replace),
        .push_addr (pc_next_seq),
        .top_addr  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            fault_addr_q <= '0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_addr_q <= fault_addr_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        halt_pend_d  = halt_pend_q;
        load         = 1'b0;
        target       = '0;
        want_push    = 1'b0;
        want_pop     = 1'b0;
        want_replace = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        ras_replace  = 1'b0;

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (trap_valid) begin
                    load   = 1'b1;
                    target = trap_vector;
                    halt_pend_d = halt_pend_q | halt_req;
                end else if (redirect_valid) begin
                    load         = 1'b1;
                    target       = redirect_target;
                    want_replace = call_valid & ret_valid;
                    want_push    = call_valid & ~ret_valid;
                    want_pop     = ret_valid & ~call_valid;
                    halt_pend_d  = halt_pend_q | halt_req;
                end else if (halt_req || halt_pend_q) begin
                    state_d     = HALTED;
                    halt_pend_d = 1'b0;
                end else if (ret_valid && !stall) begin
                    // An empty stack falls back to the branch unit's predicted target without popping.
                    load     = 1'b1;
                    target   = ras_empty ? redirect_target : ras_top;
                    want_pop = ~ras_empty;
                end else if (!stall) begin
                    pc_d = pc_next_seq;
                end
            end
            HALTED: begin
                if (trap_valid) begin
                    load   = 1'b1;
                    target = trap_vector;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                if (trap_valid) begin
                    load   = 1'b1;
                    target = trap_vector;
                end
            end
            default: state_d = BOOT;
        endcase

        if (load) begin
            if (misaligned(addr_t'(target), IALIGN)) begin
                state_d      = FAULT;
                fault_addr_d = target;
                halt_pend_d  = 1'b0;
            end else begin
                state_d     = RUN;
                pc_d        = target;
                ras_push    = want_push;
                ras_pop     = want_pop;
                ras_replace = want_replace;
            end
        end
    end

endmodule
